// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings, SRAM slave FSM states and byte-lane mask helper
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HSIZE_DOUBLE  = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Byte lanes covered by a transfer of 2^size bytes starting at lane 'lo'.
  // Only meaningful for legal transfers; callers keep the low DATA_W/8 bits.
  function automatic logic [7:0] lane_mask(input logic [2:0] lo, input logic [2:0] size);
    logic [7:0] m;
    case (size)
      HSIZE_BYTE: m = 8'h01;
      HSIZE_HALF: m = 8'h03;
      HSIZE_WORD: m = 8'h0F;
      default:    m = 8'hFF;
    endcase
    return m << lo;
  endfunction

endpackage

// File: rtl/sram_be.sv
// rtl/sram_be.sv - synchronous byte-enable RAM, one write and one registered read per cycle
//   clk   : clock, rising edge
//   we    : write enable; wbe selects the byte lanes of wdata written to waddr
//   re    : read enable; rdata is loaded with mem[raddr] at the clock edge
//   rdata : registered read data, holds between reads
module sram_be #(
  parameter int    DATA_W    = 64,
  parameter int    DEPTH     = 512,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W/8-1:0]      wbe,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    // Read returns the contents before a same-edge write; the slave
    // forwards the overlapping write lanes itself.
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram.sv
// rtl/ahb_sram.sv - AHB-Lite slave SRAM with wait states, lane steering, forwarding and ERROR response
//   HCLK/HRESET      : clock (rising edge), asynchronous active-high reset
//   HSEL/HTRANS/HWRITE/HSIZE/HADDR/HREADY : address phase, accepted when HSEL & HTRANS[1] & HREADY
//   HWDATA           : write data, taken in the final data-phase cycle
//   HRDATA           : read data, enabled lanes only, other lanes 0
//   HREADYOUT/HRESP  : slave ready and OKAY/ERROR response
module ahb_sram
  import ahb_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                ADDR_W      = 64,
  parameter int                RAM_SIZE    = 4096,
  parameter logic [ADDR_W-1:0] RAM_START   = 'h0002_0000,
  parameter int                WAIT_STATES = 0,
  parameter string             INIT_FILE   = ""
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int STRB   = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB);
  localparam int DEPTH  = RAM_SIZE / STRB;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int AW1    = ADDR_W + 1;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic              acc, take, legal, done, ready_c, err_c;
  logic [7:0]        sz_b;
  logic [7:0]        mask_full;
  logic [STRB-1:0]   mask;
  logic [IDX_W-1:0]  idx;
  logic [AW1-1:0]    a_ext, lo_ext, hi_ext;

  // Data-phase state of the transfer accepted at the previous edge.
  logic              dp_valid, dp_write;
  logic [IDX_W-1:0]  dp_idx;
  logic [STRB-1:0]   dp_mask;

  // Read output steering, captured when a read is accepted.
  logic [STRB-1:0]   rd_mask, fwd_mask;
  logic [DATA_W-1:0] fwd_data, ram_q;
  logic              ram_we, ram_re;

  assign acc = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  // Range checks use one extra bit so the top of the window cannot wrap.
  assign sz_b   = 8'd1 << HSIZE;
  assign a_ext  = {1'b0, HADDR};
  assign lo_ext = {1'b0, RAM_START};
  assign hi_ext = lo_ext + AW1'(RAM_SIZE);
  assign legal  = (HSIZE <= 3'(LANE_W))
               && ((HADDR[7:0] & (sz_b - 8'd1)) == 8'd0)
               && (a_ext >= lo_ext)
               && ((a_ext + AW1'(sz_b)) <= hi_ext);

  assign mask_full = lane_mask(3'(HADDR[LANE_W-1:0]), HSIZE);
  assign mask      = mask_full[STRB-1:0];
  assign idx       = IDX_W'((HADDR - RAM_START) >> LANE_W);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready_c = 1'b1;
    err_c   = 1'b0;
    take    = 1'b0;
    case (state)
      ST_IDLE: take = acc;
      ST_WAIT: begin
        if (cnt != 3'd0) begin
          ready_c = 1'b0;
          cnt_n   = cnt - 3'd1;
        end else begin
          take    = acc;
          state_n = ST_IDLE;
        end
      end
      ST_ERR1: begin
        ready_c = 1'b0;
        err_c   = 1'b1;
        state_n = ST_ERR2;
      end
      ST_ERR2: begin
        // Ready is high here but nothing is accepted: the bus sees the
        // second ERROR cycle and any new address phase is dropped.
        err_c   = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (take) begin
      if (!legal) begin
        state_n = ST_ERR1;
      end else if (WAIT_STATES != 0) begin
        state_n = ST_WAIT;
        cnt_n   = 3'(WAIT_STATES);
      end else begin
        state_n = ST_IDLE;
      end
    end
  end

  assign done      = dp_valid & ready_c;
  assign ram_we    = done & dp_write;
  assign ram_re    = take & legal & ~HWRITE;
  assign HREADYOUT = ready_c;
  assign HRESP     = err_c ? HRESP_ERROR : HRESP_OKAY;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_mask  <= '0;
      rd_mask  <= '0;
      fwd_mask <= '0;
      fwd_data <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (take && legal) begin
        dp_valid <= 1'b1;
        dp_write <= HWRITE;
        dp_idx   <= idx;
        dp_mask  <= mask;
      end else if (done) begin
        dp_valid <= 1'b0;
      end
      if (ram_re) begin
        rd_mask  <= mask;
        // A write completing on this same edge to the same word is not yet
        // visible in the RAM read, so its overlapping lanes come from HWDATA.
        fwd_mask <= (ram_we && (dp_idx == idx)) ? (dp_mask & mask) : '0;
        fwd_data <= HWDATA;
      end
    end
  end

  sram_be #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_mem (
    .clk  (HCLK),
    .we   (ram_we),
    .waddr(dp_idx),
    .wbe  (dp_mask),
    .wdata(HWDATA),
    .re   (ram_re),
    .raddr(idx),
    .rdata(ram_q)
  );

  always_comb begin
    HRDATA = '0;
    for (int i = 0; i < STRB; i++) begin
      if (rd_mask[i]) HRDATA[8*i +: 8] = fwd_mask[i] ? fwd_data[8*i +: 8] : ram_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_sram.sv
// tb/tb_ahb_sram.sv - directed self-checking bench for ahb_sram (64-bit, 32-bit and 3-wait-state instances)
module tb_ahb_sram;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] haddr, hwdata;
  logic [63:0] rdata0, rdata2;
  logic [31:0] rdata1;
  logic        rdy0, rdy1, rdy2, resp0, resp1, resp2;
  int          checks = 0;
  int          errors = 0;
  int          lows;

  always #5 clk = ~clk;

  ahb_sram #(.WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[0]), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata), .HREADY(rdy0),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb_sram #(.DATA_W(32)) u1 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[1]), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata[31:0]), .HREADY(rdy1),
    .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1)
  );

  ahb_sram #(.WAIT_STATES(3)) u2 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[2]), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata), .HREADY(rdy2),
    .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2)
  );

  function automatic logic rdy_of(input int w);
    return (w == 0) ? rdy0 : (w == 1) ? rdy1 : rdy2;
  endfunction

  function automatic logic resp_of(input int w);
    return (w == 0) ? resp0 : (w == 1) ? resp1 : resp2;
  endfunction

  function automatic logic [63:0] rdata_of(input int w);
    return (w == 0) ? rdata0 : (w == 1) ? {32'h0, rdata1} : rdata2;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr(input int w, input logic wr, input logic [2:0] sz, input logic [63:0] a);
    sel    = '0;
    sel[w] = 1'b1;
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic idle();
    sel    = '0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  task automatic write(input int w, input logic [2:0] sz, input logic [63:0] a, input logic [63:0] d);
    addr(w, 1'b1, sz, a);
    tick();
    hwdata = d;
    idle();
    tick();
  endtask

  task automatic read(input int w, input logic [2:0] sz, input logic [63:0] a,
                      input logic [63:0] exp, input string tag);
    addr(w, 1'b0, sz, a);
    tick();
    idle();
    check(tag, rdata_of(w), exp);
  endtask

  // Illegal transfer, then a write presented in ERR2 which must be dropped.
  task automatic err_seq(input string tag, input int w, input logic wr,
                         input logic [2:0] sz, input logic [63:0] a);
    addr(w, wr, sz, a);
    tick();
    idle();
    hwdata = '1;
    check({tag, "_err1_ready"}, rdy_of(w), 1'b0);
    check({tag, "_err1_resp"}, resp_of(w), 1'b1);
    tick();
    check({tag, "_err2_ready"}, rdy_of(w), 1'b1);
    check({tag, "_err2_resp"}, resp_of(w), 1'b1);
    addr(w, 1'b1, HSIZE_WORD, 64'h2_0000 | ((w == 1) ? 64'h4 : 64'h0));
    tick();
    idle();
    hwdata = '0;
    check({tag, "_after_resp"}, resp_of(w), 1'b0);
    tick();
  endtask

  task automatic count_wait();
    lows = 0;
    while (!rdy2 && lows < 10) begin
      lows++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    idle();
    hwdata = '0;
    haddr  = '0;
    hsize  = '0;
    rst    = 1'b1;
    tick();
    tick();
    check("rst_ready", rdy0, 1'b1);
    check("rst_resp", resp0, 1'b0);
    check("rst_rdata", rdata0, 64'h0);
    rst = 1'b0;
    tick();

    write(0, HSIZE_DOUBLE, 64'h2_0000, 64'h1122_3344_5566_7788);
    read(0, HSIZE_DOUBLE, 64'h2_0000, 64'h1122_3344_5566_7788, "rd_double");
    check("rd_ready", rdy0, 1'b1);
    write(0, HSIZE_BYTE, 64'h2_0003, 64'hFFFF_FFFF_AAFF_FFFF);
    read(0, HSIZE_DOUBLE, 64'h2_0000, 64'h1122_3344_AA66_7788, "rd_after_byte");
    read(0, HSIZE_HALF, 64'h2_0002, 64'h0000_0000_AA66_0000, "rd_half");
    read(0, HSIZE_BYTE, 64'h2_0005, 64'h0000_3300_0000_0000, "rd_byte5");

    addr(0, 1'b1, HSIZE_WORD, 64'h2_0010);
    tick();
    hwdata = 64'h5555_5555_DEAD_BEEF;
    addr(0, 1'b0, HSIZE_WORD, 64'h2_0010);
    tick();
    idle();
    check("fwd_word", rdata0, 64'h0000_0000_DEAD_BEEF);
    addr(0, 1'b1, HSIZE_WORD, 64'h2_0014);
    tick();
    hwdata = 64'hCAFE_F00D_7777_7777;
    addr(0, 1'b0, HSIZE_DOUBLE, 64'h2_0010);
    tick();
    idle();
    check("fwd_partial", rdata0, 64'hCAFE_F00D_DEAD_BEEF);
    tick();
    read(0, HSIZE_DOUBLE, 64'h2_0010, 64'hCAFE_F00D_DEAD_BEEF, "rd_after_fwd");

    write(0, HSIZE_DOUBLE, 64'h2_0FF8, 64'h0102_0304_0506_0708);
    read(0, HSIZE_DOUBLE, 64'h2_0FF8, 64'h0102_0304_0506_0708, "rd_top");
    err_seq("err_range", 0, 1'b1, HSIZE_WORD, 64'h2_1000);
    err_seq("err_below", 0, 1'b0, HSIZE_WORD, 64'h1_FFFC);
    err_seq("err_misalign", 0, 1'b1, HSIZE_HALF, 64'h2_0001);
    check("err_rdata_hold", rdata0, 64'h0102_0304_0506_0708);
    read(0, HSIZE_DOUBLE, 64'h2_0000, 64'h1122_3344_AA66_7788, "mem_intact");

    write(1, HSIZE_WORD, 64'h2_0004, 64'h0000_0000_0BAD_F00D);
    read(1, HSIZE_WORD, 64'h2_0004, 64'h0BAD_F00D, "u1_word");
    read(1, HSIZE_HALF, 64'h2_0006, 64'h0BAD_0000, "u1_half");
    err_seq("err_dw32", 1, 1'b1, HSIZE_DOUBLE, 64'h2_0000);
    read(1, HSIZE_WORD, 64'h2_0004, 64'h0BAD_F00D, "u1_intact");

    addr(2, 1'b1, HSIZE_WORD, 64'h2_0008);
    tick();
    hwdata = 64'h0000_0000_1234_5678;
    idle();
    count_wait();
    check("ws_wr_low", 64'(lows), 64'd3);
    tick();
    addr(2, 1'b0, HSIZE_WORD, 64'h2_0008);
    tick();
    idle();
    count_wait();
    check("ws_rd_low", 64'(lows), 64'd3);
    check("ws_rd_data", rdata2, 64'h0000_0000_1234_5678);
    tick();

    addr(2, 1'b1, HSIZE_WORD, 64'h2_0008);
    tick();
    hwdata = '1;
    idle();
    check("ws_wait1", rdy2, 1'b0);
    tick();
    check("ws_wait2", rdy2, 1'b0);
    rst = 1'b1;
    #1;
    check("ws_rst_ready", rdy2, 1'b1);
    check("ws_rst_resp", resp2, 1'b0);
    check("ws_rst_rdata", rdata2, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    addr(2, 1'b0, HSIZE_WORD, 64'h2_0008);
    tick();
    idle();
    count_wait();
    check("ws_after_rst_low", 64'(lows), 64'd3);
    check("ws_no_commit", rdata2, 64'h0000_0000_1234_5678);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
